mod_counter: RTL and testbench

Parametrised modulo up/down counter, the successor of the basic 4-bit counter in the 8-bit computer. Adds count enable, an arbitrary modulus, a terminal-count output, a registered wrap pulse, a sticky overflow flag, and an optional saturating mode. Used as the program counter, the step counter, and loop/delay counters in the control path.

---
 rtl/mod_counter.sv | 91 +++++++++
 tb/tb_mod_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with load, terminal count, wrap pulse and sticky overflow.
// Optional saturating mode is compiled in by defining MOD_COUNTER_SAT_EN (adds the sat port).
`timescale 1ns/1ps

module mod_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             down,
    input  logic [WIDTH-1:0] data,
    input  logic             ovf_clr,
`ifdef MOD_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable for the load range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_limit;
    logic             w_sat_mode;
    logic             w_limit_event;
    logic             w_wrap_event;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_ovf_nxt;

`ifdef MOD_COUNTER_SAT_EN
    assign w_sat_mode = sat;
`else
    assign w_sat_mode = 1'b0;
`endif

    assign w_at_limit    = down ? (r_count == '0) : (r_count == MAX_VAL);
    assign w_limit_event = !load && en && w_at_limit;
    assign w_wrap_event  = w_limit_event && !w_sat_mode;
    assign w_load_val    = ({1'b0, data} < MOD_EXT) ? data : MAX_VAL;

    always_comb begin
        // NOTE: default first so every path assigns w_count_nxt and no latch is inferred.
        w_count_nxt = r_count;
        if (load) begin
            w_count_nxt = w_load_val;
        end else if (en) begin
            if (w_at_limit) begin
                if (!w_sat_mode) begin
                    w_count_nxt = down ? MAX_VAL : '0;
                end
            end else if (down) begin
                w_count_nxt = r_count - WIDTH'(1);
            end else begin
                w_count_nxt = r_count + WIDTH'(1);
            end
        end
    end

    // A limit event on the same edge as ovf_clr keeps the flag set.
    assign w_ovf_nxt = w_limit_event || (r_ovf && !ovf_clr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking so all three registers sample pre-edge values together.
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_event;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign ovf   = r_ovf;
    assign tc    = en && w_at_limit;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MODULUS=10): vector table, hand sequences,
// and a randomised phase against a small reference model, all through an expectation queue.
`timescale 1ns/1ps

module tb_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic       down;
    logic [3:0] data;
    logic       ovf_clr;
    logic       sat;
    logic [3:0] count;
    logic       tc;
    logic       wrap;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       wrp;
        logic       ov;
    } exp_t;

    typedef struct {
        logic       ld;
        logic       e;
        logic       d;
        logic [3:0] dat;
        logic       clr;
        logic       xtc;
        logic [3:0] xcnt;
        logic       xwrap;
        logic       xovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (load),
        .down    (down),
        .data    (data),
        .ovf_clr (ovf_clr),
`ifdef MOD_COUNTER_SAT_EN
        .sat     (sat),
`endif
        .count   (count),
        .tc      (tc),
        .wrap    (wrap),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary before 200000ns");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive, check tc, queue the post-edge expectation, clock, compare.
    task automatic apply(input logic l, input logic e, input logic d, input logic [3:0] dat,
                         input logic c, input logic s, input logic xtc,
                         input logic [3:0] xcnt, input logic xw, input logic xo,
                         input string tag);
        exp_t got;
        load    = l;
        en      = e;
        down    = d;
        data    = dat;
        ovf_clr = c;
        sat     = s;
        #1;
        check({tag, " tc"}, 32'(tc), 32'(xtc));
        sb.push_back('{cnt: xcnt, wrp: xw, ov: xo});
        @(posedge clk);
        @(negedge clk);
        if (sb.size() == 0) begin
            check({tag, " queue"}, 32'(0), 32'(1));
        end else begin
            got = sb.pop_front();
            check({tag, " count"}, 32'(count), 32'(got.cnt));
            check({tag, " wrap"},  32'(wrap),  32'(got.wrp));
            check({tag, " ovf"},   32'(ovf),   32'(got.ov));
        end
    endtask

    task automatic idle_inputs();
        load = 1'b0; en = 1'b0; down = 1'b0; data = 4'd0; ovf_clr = 1'b0; sat = 1'b0;
    endtask

    int   m_cnt;
    logic m_ovf;

    initial begin
        rst = 1'b0;
        idle_inputs();

        // Fields: load en down data clr | tc count wrap ovf (tc is pre-edge, rest post-edge)
        for (int i = 0; i < 12; i++) begin
            vecs.push_back('{ld: 0, e: 1, d: 0, dat: 0, clr: 0, xtc: (i == 9),
                             xcnt: 4'((i + 1) % 10), xwrap: (i == 9), xovf: (i >= 9)});
        end
        vecs.push_back('{1, 0, 0, 4'd2,  0, 0, 4'd2, 0, 1});  // load 2
        vecs.push_back('{0, 1, 1, 4'd0,  0, 0, 4'd1, 0, 1});  // down 2->1
        vecs.push_back('{0, 1, 1, 4'd0,  0, 0, 4'd0, 0, 1});  // down 1->0
        vecs.push_back('{0, 1, 1, 4'd0,  0, 1, 4'd9, 1, 1});  // down wrap 0->9
        vecs.push_back('{0, 1, 1, 4'd0,  0, 0, 4'd8, 0, 1});  // down 9->8
        vecs.push_back('{1, 1, 0, 4'd14, 0, 0, 4'd9, 0, 1});  // clamp, load beats en
        vecs.push_back('{0, 1, 0, 4'd0,  1, 1, 4'd0, 1, 1});  // wrap + clr: set wins
        vecs.push_back('{0, 0, 0, 4'd0,  1, 0, 4'd0, 0, 0});  // clr alone
        vecs.push_back('{0, 0, 0, 4'd0,  0, 0, 4'd0, 0, 0});  // hold
        vecs.push_back('{1, 1, 0, 4'd10, 0, 0, 4'd9, 0, 0});  // data==MODULUS clamps
        vecs.push_back('{1, 1, 0, 4'd9,  0, 1, 4'd9, 0, 0});  // load at limit: no event
        vecs.push_back('{0, 1, 0, 4'd0,  0, 1, 4'd0, 1, 1});  // up wrap 9->0
        vecs.push_back('{0, 1, 0, 4'd0,  0, 0, 4'd1, 0, 1});  // wrap is one cycle
        vecs.push_back('{0, 0, 0, 4'd0,  0, 0, 4'd1, 0, 1});  // hold
        vecs.push_back('{0, 1, 1, 4'd0,  0, 0, 4'd0, 0, 1});  // reverse 1->0
        vecs.push_back('{0, 1, 1, 4'd0,  0, 1, 4'd9, 1, 1});  // down wrap
        vecs.push_back('{0, 1, 0, 4'd0,  0, 1, 4'd0, 1, 1});  // immediate up wrap
        vecs.push_back('{0, 1, 0, 4'd0,  0, 0, 4'd1, 0, 1});
        vecs.push_back('{1, 0, 0, 4'd5,  0, 0, 4'd5, 0, 1});  // load 5 before reset test

        // Reset held, including across an enabled edge.
        @(negedge clk);
        check("reset count", 32'(count), 32'd0);
        check("reset wrap",  32'(wrap),  32'd0);
        check("reset ovf",   32'(ovf),   32'd0);
        en = 1'b1;
        @(negedge clk);
        check("reset hold count", 32'(count), 32'd0);
        en = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ld, vecs[i].e, vecs[i].d, vecs[i].dat, vecs[i].clr, 1'b0,
                  vecs[i].xtc, vecs[i].xcnt, vecs[i].xwrap, vecs[i].xovf,
                  $sformatf("vec%0d", i));
        end

        // Asynchronous reset between edges while count=5, ovf=1.
        #2;
        rst = 1'b0;
        #1;
        check("async rst count", 32'(count), 32'd0);
        check("async rst wrap",  32'(wrap),  32'd0);
        check("async rst ovf",   32'(ovf),   32'd0);
        en = 1'b1;
        @(negedge clk);
        check("rst held count", 32'(count), 32'd0);
        rst = 1'b1;
        apply(0, 1, 0, 4'd0, 0, 0, 0, 4'd1, 0, 0, "restart");

`ifdef MOD_COUNTER_SAT_EN
        apply(1, 0, 0, 4'd8, 0, 1, 0, 4'd8, 0, 0, "sat load8");
        apply(0, 1, 0, 4'd0, 0, 1, 0, 4'd9, 0, 0, "sat up 8->9");
        apply(0, 1, 0, 4'd0, 0, 1, 1, 4'd9, 0, 1, "sat up hold1");
        apply(0, 1, 0, 4'd0, 0, 1, 1, 4'd9, 0, 1, "sat up hold2");
        apply(1, 0, 1, 4'd1, 0, 1, 0, 4'd1, 0, 1, "sat load1");
        apply(0, 1, 1, 4'd0, 0, 1, 0, 4'd0, 0, 1, "sat dn 1->0");
        apply(0, 1, 1, 4'd0, 0, 1, 1, 4'd0, 0, 1, "sat dn hold");
        apply(0, 1, 1, 4'd0, 0, 0, 1, 4'd9, 1, 1, "sat off wraps");
`endif

        // Randomised phase against a reference model, from a fresh reset.
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_cnt = 0;
        m_ovf = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic l, e, d, c, lim, xtc, evt;
            logic [3:0] dat;
            int nxt;
            l   = ($urandom_range(0, 7) == 0);
            e   = ($urandom_range(0, 3) != 0);
            d   = 1'($urandom_range(0, 1));
            c   = ($urandom_range(0, 5) == 0);
            dat = 4'($urandom_range(0, 15));
            lim = d ? (m_cnt == 0) : (m_cnt == 9);
            xtc = e && lim;
            evt = !l && xtc;
            if (l)      nxt = (dat > 4'd9) ? 9 : int'(dat);
            else if (e) nxt = d ? (m_cnt + 9) % 10 : (m_cnt + 1) % 10;
            else        nxt = m_cnt;
            m_ovf = evt || (m_ovf && !c);
            apply(l, e, d, dat, c, 0, xtc, 4'(nxt), evt, m_ovf, $sformatf("rand%0d", n));
            m_cnt = nxt;
        end

        if (sb.size() != 0) check("queue drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
